// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter: opcode encodings and default widths.
package alu_arb_pkg;

    localparam int unsigned ALU_ARB_WIDTH = 32;
    localparam int unsigned ALU_ARB_OP_W  = 3;

    localparam logic [ALU_ARB_OP_W-1:0] ALU_OP_ADD = 3'b000;
    localparam logic [ALU_ARB_OP_W-1:0] ALU_OP_SUB = 3'b100;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester handshake and shared-ALU bus for alu_share_arbiter.
// slave = arbiter side, master = requesters/ALU side.
interface alu_share_arbiter_if
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = ALU_ARB_WIDTH,
    parameter int unsigned OP_W  = ALU_ARB_OP_W
);

    logic [NREQ-1:0]       req_i;
    logic [NREQ*OP_W-1:0]  op_i;
    logic [NREQ*WIDTH-1:0] a_i;
    logic [NREQ*WIDTH-1:0] b_i;
    logic [NREQ-1:0]       lock_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       valid_o;
    logic [WIDTH-1:0]      res_o;
    logic [OP_W-1:0]       alu_op_o;
    logic [WIDTH-1:0]      alu_a_o;
    logic [WIDTH-1:0]      alu_b_o;
    logic [WIDTH-1:0]      alu_res_i;
    logic                  busy_o;

    modport slave (
        input  req_i, op_i, a_i, b_i, lock_i, alu_res_i,
        output gnt_o, valid_o, res_o, alu_op_o, alu_a_o, alu_b_o, busy_o
    );

    modport master (
        output req_i, op_i, a_i, b_i, lock_i, alu_res_i,
        input  gnt_o, valid_o, res_o, alu_op_o, alu_a_o, alu_b_o, busy_o
    );

endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);

    logic [2*NREQ-1:0] rot;
    logic              found;
    int unsigned       off;
    int unsigned       win;

    // Rotating a doubled copy puts the pointer position at bit 0, so a plain
    // lowest-bit search gives the wrap-around priority order.
    always_comb begin
        rot   = {req, req} >> ptr;
        found = 1'b0;
        off   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        win = int'(ptr) + off;
        if (win >= NREQ) begin
            win = win - NREQ;
        end
        gnt = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            gnt[k] = found && (win == k);
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin issue stage, registered result.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = ALU_ARB_WIDTH,
    parameter int unsigned OP_W  = ALU_ARB_OP_W
) (
    input logic                clk_i,
    input logic                rst_ni,
    alu_share_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_nxt;
    logic [NREQ-1:0]  eff_req;
    logic [NREQ-1:0]  pick;
    logic             any_pick;
    logic [PTR_W-1:0] win_idx;
    logic [OP_W-1:0]  win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_lock;

    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  valid_q;
    logic [WIDTH-1:0] res_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             busy_q;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (eff_req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        win_idx  = '0;
        win_op   = '0;
        win_a    = '0;
        win_b    = '0;
        win_lock = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                win_idx  = PTR_W'(k);
                win_op   = bus.op_i[k*OP_W +: OP_W];
                win_a    = bus.a_i[k*WIDTH +: WIDTH];
                win_b    = bus.b_i[k*WIDTH +: WIDTH];
                win_lock = bus.lock_i[k];
            end
        end
    end

    assign any_pick = |pick;
    assign ptr_nxt  = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

`ifdef ALU_ARB_LOCK_EN
    logic             lock_q;
    logic [PTR_W-1:0] owner_q;
    logic [NREQ-1:0]  owner_mask;
    logic             locked;

    always_comb begin
        owner_mask = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            owner_mask[k] = (PTR_W'(k) == owner_q);
        end
    end

    // A held lock masks everyone but the owner; the pointer already sits at
    // owner+1, so rr resumes there once the lock drops.
    assign locked  = lock_q && |(bus.req_i & owner_mask);
    assign eff_req = locked ? (bus.req_i & owner_mask) : bus.req_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (any_pick) begin
            lock_q  <= win_lock;
            owner_q <= win_idx;
        end else if (!locked) begin
            lock_q  <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = win_lock;
    assign eff_req     = bus.req_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= '0;
            res_q    <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            gnt_q   <= pick;
            valid_q <= gnt_q;
            busy_q  <= any_pick;
            if (|gnt_q) begin
                res_q <= bus.alu_res_i;
            end
            if (any_pick) begin
                alu_op_q <= win_op;
                alu_a_q  <= win_a;
                alu_b_q  <= win_b;
                ptr_q    <= ptr_nxt;
            end
        end
    end

    assign bus.gnt_o    = gnt_q;
    assign bus.valid_o  = valid_q;
    assign bus.res_o    = res_q;
    assign bus.alu_op_o = alu_op_q;
    assign bus.alu_a_o  = alu_a_q;
    assign bus.alu_b_o  = alu_b_q;
    assign bus.busy_o   = busy_q;

endmodule
